// File: rtl/clock_switch_sequencer_pkg.sv
// Shared types for the clock switch sequencer.
//   state_t    : sequencer FSM states
//   wait_cnt_w : width of the wait down-counter, sized so it can be loaded
//                with (max wait - 1)
package clock_switch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EXT = 2'd1,
    WAIT_DIV = 2'd2,
    WAIT_PLL = 2'd3
  } state_t;

  function automatic int wait_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clock_switch_sequencer_if.sv
// Configuration request channel from housekeeping into the sequencer.
//   cfg_valid   : request valid
//   cfg_ready   : request accepted on an edge where valid & ready
//   cfg_ext_sel : target ext_clk_sel (1 = external clock)
//   cfg_sel     : target core divider
//   cfg_sel2    : target user divider
interface clock_switch_sequencer_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_ext_sel;
  logic [2:0] cfg_sel;
  logic [2:0] cfg_sel2;

  modport master (output cfg_valid, cfg_ext_sel, cfg_sel, cfg_sel2, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ext_sel, cfg_sel, cfg_sel2, output cfg_ready);
endinterface

// File: rtl/clock_switch_sequencer_lock_timer.sv
// PLL lock wait: counts pll_clk edges from reset release and raises
// pll_ready after edge LOCK_WAIT. Holds (saturates) once ready.
//   pll_clk   : clock
//   resetb    : async active-low reset, restarts the wait
//   pll_ready : high from edge LOCK_WAIT until the next reset
module lock_timer #(
  parameter int LOCK_WAIT = 1024
) (
  input  logic pll_clk,
  input  logic resetb,
  output logic pll_ready
);

  localparam int LW = $clog2(LOCK_WAIT + 1);

  logic [LW-1:0] cnt;

  // Before edge k the counter holds k-1, so matching LOCK_WAIT-1 marks
  // edge LOCK_WAIT; the counter then freezes.
  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      cnt       <= '0;
      pll_ready <= 1'b0;
    end else if (!pll_ready) begin
      if (cnt == LW'(LOCK_WAIT - 1)) pll_ready <= 1'b1;
      else                           cnt       <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clock_switch_sequencer.sv
// Clock switch sequencer: owns ext_clk_sel / sel / sel2 of the clock block
// and walks every configuration change through a safe order: park on the
// external clock, update dividers, settle, then return to the PLL.
//   pll_clk, resetb : clock, async active-low reset
//   force_ext       : level, forces the external clock and aborts a sequence
//   cfg             : request channel (slave side)
//   ext_clk_sel     : clock mux select, 1 = external
//   sel, sel2       : core / user dividers
//   pll_ready       : lock wait complete, requests accepted from here on
//   busy            : sequence in progress
//   done, aborted   : one-cycle completion / kill pulses
module clock_switch_sequencer
  import clock_switch_pkg::*;
#(
  parameter int         SWITCH_WAIT = 4,
  parameter int         SETTLE_WAIT = 16,
  parameter int         LOCK_WAIT   = 1024,
  parameter logic [2:0] DEFAULT_SEL = 3'd0
) (
  input  logic                     pll_clk,
  input  logic                     resetb,
  input  logic                     force_ext,
  clock_switch_sequencer_if.slave  cfg,
  output logic                     ext_clk_sel,
  output logic [2:0]               sel,
  output logic [2:0]               sel2,
  output logic                     pll_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam int            CW      = wait_cnt_w(SWITCH_WAIT, SETTLE_WAIT);
  localparam logic [CW-1:0] SW_LOAD = CW'(SWITCH_WAIT - 1);
  localparam logic [CW-1:0] ST_LOAD = CW'(SETTLE_WAIT - 1);

  state_t        state;
  logic [CW-1:0] wcnt;
  logic          tgt_ext;
  logic [2:0]    tgt_sel;
  logic [2:0]    tgt_sel2;
  logic          accept;
  logic          same_cfg;
  logic          wait_end;

  lock_timer #(.LOCK_WAIT(LOCK_WAIT)) u_lock (
    .pll_clk   (pll_clk),
    .resetb    (resetb),
    .pll_ready (pll_ready)
  );

  assign cfg.cfg_ready = (state == IDLE) & pll_ready & ~force_ext;
  assign busy          = (state != IDLE);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign same_cfg      = (cfg.cfg_ext_sel == ext_clk_sel) & (cfg.cfg_sel == sel) &
                         (cfg.cfg_sel2 == sel2);
  assign wait_end      = (wcnt == '0);

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      wcnt        <= '0;
      ext_clk_sel <= 1'b1;
      sel         <= DEFAULT_SEL;
      sel2        <= DEFAULT_SEL;
      tgt_ext     <= 1'b1;
      tgt_sel     <= DEFAULT_SEL;
      tgt_sel2    <= DEFAULT_SEL;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (force_ext) begin
        // Emergency park: dividers stay where they are, target is dropped.
        ext_clk_sel <= 1'b1;
        state       <= IDLE;
        aborted     <= (state != IDLE);
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              tgt_ext  <= cfg.cfg_ext_sel;
              tgt_sel  <= cfg.cfg_sel;
              tgt_sel2 <= cfg.cfg_sel2;
              if (same_cfg) begin
                done <= 1'b1;
              end else if (!ext_clk_sel) begin
                // On PLL: move to external first, dividers wait for the mux.
                ext_clk_sel <= 1'b1;
                wcnt        <= SW_LOAD;
                state       <= WAIT_EXT;
              end else begin
                sel   <= cfg.cfg_sel;
                sel2  <= cfg.cfg_sel2;
                wcnt  <= ST_LOAD;
                state <= WAIT_DIV;
              end
            end
          end
          WAIT_EXT: begin
            if (wait_end) begin
              sel   <= tgt_sel;
              sel2  <= tgt_sel2;
              wcnt  <= ST_LOAD;
              state <= WAIT_DIV;
            end else begin
              wcnt <= wcnt - 1'b1;
            end
          end
          WAIT_DIV: begin
            if (wait_end) begin
              if (!tgt_ext) begin
                ext_clk_sel <= 1'b0;
                wcnt        <= SW_LOAD;
                state       <= WAIT_PLL;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              wcnt <= wcnt - 1'b1;
            end
          end
          WAIT_PLL: begin
            if (wait_end) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              wcnt <= wcnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_switch_sequencer.sv
module tb_clock_switch_sequencer;
  localparam int SW = 4;
  localparam int ST = 16;
  localparam int LW = 1024;

  logic       pll_clk = 1'b0;
  logic       resetb = 1'b0;
  logic       force_ext = 1'b0;
  logic       ext_clk_sel;
  logic [2:0] sel;
  logic [2:0] sel2;
  logic       pll_ready, busy, done, aborted;

  clock_switch_sequencer_if cfg_if();

  clock_switch_sequencer #(
    .SWITCH_WAIT(SW), .SETTLE_WAIT(ST), .LOCK_WAIT(LW), .DEFAULT_SEL(3'd0)
  ) dut (
    .pll_clk     (pll_clk),
    .resetb      (resetb),
    .force_ext   (force_ext),
    .cfg         (cfg_if),
    .ext_clk_sel (ext_clk_sel),
    .sel         (sel),
    .sel2        (sel2),
    .pll_ready   (pll_ready),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  always #5 pll_clk = ~pll_clk;

  // Expected pulse: done (abort=0) or aborted (abort=1), the edge it follows,
  // and the clock configuration visible at that point.
  typedef struct {
    bit       abort;
    int       cyc;
    bit       ext;
    bit [2:0] s;
    bit [2:0] s2;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: an accepted request is turned into a schedule of edge
  // numbers at which outputs change, derived from the documented timelines.
  int       cyc = 0;
  int       m_lock = 0;
  bit       m_ext = 1'b1;
  bit       m_act = 1'b0;
  bit       rst_evt = 1'b1;
  bit [2:0] m_sel = 3'd0;
  bit [2:0] m_sel2 = 3'd0;
  bit       t_ext;
  bit [2:0] t_sel, t_sel2;
  int       t_selcyc = -1;
  int       t_ext0cyc = -1;
  int       t_done = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge pll_clk or negedge resetb);
      if (!resetb) begin
        cyc = 0; m_lock = 0; m_ext = 1'b1; m_sel = 3'd0; m_sel2 = 3'd0;
        m_act = 1'b0; q.delete(); rst_evt = 1'b1;
      end else begin : step
        bit rdy;
        rdy = !m_act && (m_lock >= LW) && !force_ext;
        cyc++;
        if (m_lock < LW) m_lock++;
        if (force_ext) begin
          if (m_act) begin
            void'(q.pop_back());
            q.push_back('{1'b1, cyc, 1'b1, m_sel, m_sel2});
            m_act = 1'b0;
          end
          m_ext = 1'b1;
        end else if (m_act) begin
          if (cyc == t_selcyc) begin m_sel = t_sel; m_sel2 = t_sel2; end
          if (cyc == t_ext0cyc) m_ext = 1'b0;
          if (cyc == t_done) m_act = 1'b0;
        end else if (cfg_if.cfg_valid && rdy) begin
          t_ext = cfg_if.cfg_ext_sel; t_sel = cfg_if.cfg_sel; t_sel2 = cfg_if.cfg_sel2;
          if (t_ext == m_ext && t_sel == m_sel && t_sel2 == m_sel2) begin
            q.push_back('{1'b0, cyc, m_ext, m_sel, m_sel2});
          end else begin
            m_act = 1'b1;
            if (!m_ext) begin
              m_ext = 1'b1;
              t_selcyc  = cyc + SW;
              t_ext0cyc = t_ext ? -1 : cyc + SW + ST;
              t_done    = cyc + SW + ST + (t_ext ? 0 : SW);
            end else begin
              m_sel = t_sel; m_sel2 = t_sel2;
              t_selcyc  = -1;
              t_ext0cyc = t_ext ? -1 : cyc + ST;
              t_done    = cyc + ST + (t_ext ? 0 : SW);
            end
            q.push_back('{1'b0, t_done, t_ext, t_sel, t_sel2});
          end
        end
      end
    end
  end

  // Monitor: per-cycle output check, pulse scoreboard, divider-safety check.
  initial begin
    bit [2:0] ps, ps2;
    bit       pe;
    bit       have_prev;
    exp_t     e;
    have_prev = 1'b0;
    forever begin
      @(negedge pll_clk);
      chk("outputs", {cfg_if.cfg_ready, busy, pll_ready, ext_clk_sel, sel, sel2},
          {!m_act && (m_lock >= LW) && !force_ext, m_act, m_lock >= LW, m_ext, m_sel, m_sel2});
      if (done || aborted || (q.size() > 0 && q[0].cyc == cyc)) begin
        if (q.size() == 0) begin
          chk("spurious_pulse", {done, aborted}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("pulse_edge", cyc, e.cyc);
          chk("pulse_kind", {done, aborted}, e.abort ? 2'b01 : 2'b10);
          chk("pulse_cfg", {ext_clk_sel, sel, sel2}, {e.ext, e.s, e.s2});
        end
      end
      if (have_prev && !rst_evt && {sel, sel2} != {ps, ps2})
        chk("div_change_safe", {pe, ext_clk_sel}, 2'b11);
      ps = sel; ps2 = sel2; pe = ext_clk_sel; have_prev = 1'b1; rst_evt = 1'b0;
    end
  end

  task automatic send(input bit e, input bit [2:0] s, input bit [2:0] s2, input bit keep,
                      output int acc);
    int  n;
    bit  r;
    bit  took;
    n = 0; took = 1'b0; acc = -1;
    @(negedge pll_clk);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ext_sel = e; cfg_if.cfg_sel = s; cfg_if.cfg_sel2 = s2;
    while (!took && n < 3000) begin
      #1 r = cfg_if.cfg_ready;
      @(posedge pll_clk);
      n++;
      if (r) took = 1'b1;
      else @(negedge pll_clk);
    end
    chk("accept_timeout", {31'd0, took}, 32'd1);
    #1 acc = cyc;
    if (!keep) begin
      @(negedge pll_clk);
      cfg_if.cfg_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge pll_clk);
      n++;
    end while (busy && n < 200);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int       acc;
    bit       e;
    bit [2:0] s, s2;
    bit       keep;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ext_sel = 1'b1;
    cfg_if.cfg_sel = 3'd0; cfg_if.cfg_sel2 = 3'd0;
    repeat (3) @(negedge pll_clk);
    chk("reset_state", {ext_clk_sel, sel, sel2, pll_ready, busy, done, aborted, cfg_if.cfg_ready},
        {1'b1, 3'd0, 3'd0, 5'b0});
    resetb = 1'b1;

    // Valid held through the lock wait; accept lands on edge LW+1.
    send(1'b0, 3'd3, 3'd5, 1'b0, acc);
    chk("first_accept_edge", acc, LW + 1);
    wait_idle();
    send(1'b0, 3'd2, 3'd2, 1'b0, acc);   // PLL -> PLL
    wait_idle();
    send(1'b0, 3'd2, 3'd2, 1'b0, acc);   // identical
    wait_idle();
    send(1'b1, 3'd4, 3'd1, 1'b0, acc);   // PLL -> ext
    wait_idle();
    send(1'b1, 3'd6, 3'd7, 1'b0, acc);   // ext -> ext
    wait_idle();
    send(1'b0, 3'd5, 3'd5, 1'b0, acc);   // ext -> PLL
    wait_idle();

    // Abort a PLL -> PLL sequence on edge 10 after accept.
    send(1'b0, 3'd1, 3'd1, 1'b0, acc);
    repeat (9) @(posedge pll_clk);
    @(negedge pll_clk);
    force_ext = 1'b1;
    repeat (5) @(negedge pll_clk);
    force_ext = 1'b0;
    wait_idle();

    // Random requests, some back-to-back with valid held, some forced off.
    repeat (40) begin
      e = 1'($urandom_range(0, 1)); s = 3'($urandom_range(0, 7)); s2 = 3'($urandom_range(0, 7));
      keep = ($urandom_range(0, 3) == 0);
      if (!m_act && $urandom_range(0, 4) == 0) begin e = m_ext; s = m_sel; s2 = m_sel2; keep = 1'b0; end
      send(e, s, s2, keep, acc);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 30)) @(negedge pll_clk);
        force_ext = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge pll_clk);
        force_ext = 1'b0;
      end else if (!keep) begin
        wait_idle();
      end
    end
    @(negedge pll_clk);
    cfg_if.cfg_valid = 1'b0;
    wait_idle();

    // Reset during WAIT_DIV: park on external first so accept goes straight there.
    @(negedge pll_clk);
    force_ext = 1'b1;
    @(negedge pll_clk);
    force_ext = 1'b0;
    send(1'b0, 3'd2, 3'd6, 1'b0, acc);
    repeat (5) @(negedge pll_clk);
    #2 resetb = 1'b0;
    #1 chk("async_reset", {ext_clk_sel, sel, sel2, pll_ready, busy, done, aborted, cfg_if.cfg_ready},
           {1'b1, 3'd0, 3'd0, 5'b0});
    @(negedge pll_clk);
    resetb = 1'b1;
    send(1'b0, 3'd7, 3'd1, 1'b0, acc);
    chk("relock_accept_edge", acc, LW + 1);
    wait_idle();

    repeat (3) @(negedge pll_clk);
    chk("pulses_outstanding", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_switch_sequencer.md
Name: clock_switch_sequencer

Overview:
- Owns the clock-block controls `ext_clk_sel`, `sel` and `sel2`; housekeeping submits a target configuration through a valid/ready handshake.
- Sequences every change safely: park on the external clock, change the dividers, let them settle, then return to the PLL.
- Blocks all requests until the PLL has run `LOCK_WAIT` cycles after reset.
- `force_ext` is an emergency override back to the external clock.

Parameters:
- SWITCH_WAIT, 4: cycles held after any `ext_clk_sel` change before the next step (covers the clock mux's 2-flop use_pll synchroniser); must be >= 1.
- SETTLE_WAIT, 16: cycles held after a divider update before continuing; must be >= 1.
- LOCK_WAIT, 1024: `pll_clk` cycles after reset release before `pll_ready` asserts; must be >= 1.
- DEFAULT_SEL, 3'd0: reset value of `sel` and `sel2`.

Ports:
- pll_clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- force_ext  in  1  level; forces external clock and aborts any sequence
- cfg_valid  in  1  request valid
- cfg_ready  out  1  request accept
- cfg_ext_sel  in  1  target `ext_clk_sel` (1 = external)
- cfg_sel  in  3  target core divider
- cfg_sel2  in  3  target user divider
- ext_clk_sel  out  1  to clock block
- sel  out  3  to clock block
- sel2  out  3  to clock block
- pll_ready  out  1  lock wait complete
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence completed
- aborted  out  1  one-cycle pulse, sequence killed by `force_ext`

Behaviour:
- Reset values: `ext_clk_sel`=1, `sel`=`sel2`=DEFAULT_SEL, `pll_ready`=0, `busy`=0, `done`=0, `aborted`=0, state IDLE.
- All outputs are registered except `cfg_ready` and `busy`.
- Lock counter: counts from 0 after reset release; `pll_ready` goes high after edge LOCK_WAIT and stays high until reset. Counter saturates.
- `cfg_ready` = (state==IDLE) & `pll_ready` & ~`force_ext`. `busy` = (state!=IDLE).
- Accept occurs at edge e0 when `cfg_valid` & `cfg_ready`. Targets are latched at e0; inputs are ignored afterwards.
- Each wait state lasts exactly N cycles using a down-counter loaded with N-1 and leaving when it reaches 0. The counter is sized for max(SWITCH_WAIT, SETTLE_WAIT).
- States and actions at e0, by case:
  - No change (target equals current in all three fields): stay IDLE; `done` pulses after e0.
  - Currently on PLL (`ext_clk_sel`=0), target not identical: `ext_clk_sel`<=1; go WAIT_EXT.
  - Currently external: `sel`/`sel2`<=targets; go WAIT_DIV.
- Transitions after e0:
  - WAIT_EXT, end: `sel`/`sel2`<=targets; go WAIT_DIV.
  - WAIT_DIV, end, target PLL: `ext_clk_sel`<=0; go WAIT_PLL.
  - WAIT_DIV, end, target external: go IDLE, `done`<=1.
  - WAIT_PLL, end: go IDLE, `done`<=1.
- Resulting timelines (edges counted from e0):
  - PLL->PLL: `ext_clk_sel` 1 after e0; `sel` after e[SW]; `ext_clk_sel` 0 after e[SW+SETTLE]; `done` after e[2SW+SETTLE].
  - Ext->PLL: `sel` after e0; `ext_clk_sel` 0 after e[SETTLE]; `done` after e[SETTLE+SW].
  - Ext->ext: `done` after e[SETTLE].
  - PLL->ext: `done` after e[SW+SETTLE].
- `ext_clk_sel` and the dividers never change on the same edge. The dividers change only while `ext_clk_sel`=1.
- `force_ext` high, sampled in any state:
  - `ext_clk_sel`<=1 and state<=IDLE.
  - `aborted`<=1 if the state was not IDLE.
  - `sel`/`sel2` keep their current values.
  - While `force_ext` is high, no request is accepted. The latched target is discarded.
- `force_ext` on the accept edge cannot happen, because `cfg_ready` is already low.
- `cfg_valid` held high after `done`: a new accept occurs on the first IDLE cycle with `cfg_ready`.
- Reset mid-sequence: everything returns to reset values immediately (asynchronous). The lock wait restarts.

Decomposition:
- Package `clock_switch_pkg`: state enum (IDLE, WAIT_EXT, WAIT_DIV, WAIT_PLL) and a counter-width function based on `$clog2`.
- One sub-module, `lock_timer`: saturating LOCK_WAIT counter producing `pll_ready`.
- FSM, wait counter and output registers stay in the top module.

Test Plan:
- Reset, then hold `cfg_valid`=1 -> `cfg_ready`=0 for 1024 cycles; `pll_ready` and accept at cycle 1025; `ext_clk_sel`=1, `sel`=0 after reset.
- From external, request (0,3,5) -> `sel`=3/`sel2`=5 after e0; `ext_clk_sel`=0 after e16; `done` after e20; `busy` high e0..e19.
- From PLL, request (0,2,2) -> `ext_clk_sel`=1 after e0; `sel`=2 after e4; `ext_clk_sel`=0 after e20; `done` after e24. Check `ext_clk_sel` and `sel` never change on the same edge.
- Request identical to current -> `done` after e0, no output change, `cfg_ready` back the next cycle.
- Assert `force_ext` at e10 of a PLL->PLL sequence -> `ext_clk_sel`=1, `aborted` pulse, `sel` unchanged or new per its edge, `cfg_ready`=0 until `force_ext` drops.
- Deassert `resetb` during WAIT_DIV -> outputs at reset values immediately; `pll_ready` low again for 1024 cycles.
